// File: rtl/xvga_pkg.sv
// Shared constants for the XVGA raster path: 1024x768@60 default timing,
// coordinate widths and the phase encoding used by both axis counters.
package xvga_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  localparam int H_ACTIVE_DEF = 1024;
  localparam int H_FP_DEF     = 24;
  localparam int H_SYNC_DEF   = 136;
  localparam int H_BP_DEF     = 160;

  localparam int V_ACTIVE_DEF = 768;
  localparam int V_FP_DEF     = 3;
  localparam int V_SYNC_DEF   = 6;
  localparam int V_BP_DEF     = 29;

  localparam logic SYNC_POL_DEF = 1'b0;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FP,
    PH_SYNC,
    PH_BP
  } phase_t;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/xvga_axis_counter.sv
// One raster axis: wrapping position counter, ACTIVE/FP/SYNC/BP phase FSM and
// a registered sync output. Used once per line (horizontal) and once per frame.
module xvga_axis_counter
  import xvga_pkg::*;
#(
  parameter int   W        = 11,
  parameter int   ACTIVE   = 1024,
  parameter int   FP       = 24,
  parameter int   SYNC     = 136,
  parameter int   BP       = 160,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic         vclock,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output phase_t       phase,
  output logic         wrap,
  output logic         sync
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [W-1:0] ACT_LAST  = W'(ACTIVE - 1);
  localparam logic [W-1:0] FP_LAST   = W'(ACTIVE + FP - 1);
  localparam logic [W-1:0] SYNC_LAST = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] LAST      = W'(TOTAL - 1);

  phase_t phase_next;

  assign wrap = en && (count == LAST);

  // sync is registered from the next phase so it lines up with count
  always_ff @(posedge vclock) begin
    if (reset) begin
      count <= '0;
      phase <= PH_ACTIVE;
      sync  <= ~SYNC_POL;
    end else begin
      if (en) begin
        count <= wrap ? '0 : count + 1'b1;
      end
      phase <= phase_next;
      sync  <= (phase_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    end
  end

  always_comb begin
    phase_next = phase;
    if (en) begin
      case (phase)
        PH_ACTIVE: if (count == ACT_LAST)  phase_next = PH_FP;
        PH_FP:     if (count == FP_LAST)   phase_next = PH_SYNC;
        PH_SYNC:   if (count == SYNC_LAST) phase_next = PH_BP;
        PH_BP:     if (count == LAST)      phase_next = PH_ACTIVE;
        default:   phase_next = PH_ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/xvga_timing.sv
// Free-running XVGA raster generator producing hcount/vcount, syncs and blank.
// Optional frame counter output is enabled by defining XVGA_FRAME_COUNT_EN.
module xvga_timing
  import xvga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = SYNC_POL_DEF
) (
  input  logic                vclock,
  input  logic                reset,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [VCOUNT_W-1:0] vcount,
  output logic                hsync,
  output logic                vsync,
  output logic                blank,
  output logic                line_start,
  output logic                frame_start
`ifdef XVGA_FRAME_COUNT_EN
  ,
  output logic [15:0]         frame_count
`endif
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_size_check
    $error("xvga_timing: raster totals exceed hcount/vcount widths");
  end

  phase_t h_phase;
  phase_t v_phase;
  logic   h_wrap;
  logic   v_wrap;

  xvga_axis_counter #(
    .W(HCOUNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .SYNC_POL(SYNC_POL)
  ) u_horiz (
    .vclock (vclock),
    .reset  (reset),
    .en     (1'b1),
    .count  (hcount),
    .phase  (h_phase),
    .wrap   (h_wrap),
    .sync   (hsync)
  );

  xvga_axis_counter #(
    .W(VCOUNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_vert (
    .vclock (vclock),
    .reset  (reset),
    .en     (h_wrap),
    .count  (vcount),
    .phase  (v_phase),
    .wrap   (v_wrap),
    .sync   (vsync)
  );

  // Both phases are registered alongside the counters, so blank has no skew
  assign blank = (h_phase != PH_ACTIVE) || (v_phase != PH_ACTIVE);

  always_ff @(posedge vclock) begin
    if (reset) begin
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end
  end

`ifdef XVGA_FRAME_COUNT_EN
  always_ff @(posedge vclock) begin
    if (reset) begin
      frame_count <= 16'd0;
    end else if (h_wrap && v_wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xvga_timing.sv
// Directed checks of xvga_timing: full-size instance for line timing, and a
// reduced-raster instance (16x11) for whole-frame, mid-frame reset and frame_count.
module tb_xvga_timing;

  logic        vclock = 1'b0;
  logic        reset  = 1'b1;
  logic        reset_s = 1'b1;

  logic [10:0] hcount, hcount_s;
  logic [9:0]  vcount, vcount_s;
  logic        hsync, vsync, blank, line_start, frame_start;
  logic        hsync_s, vsync_s, blank_s, line_start_s, frame_start_s;
`ifdef XVGA_FRAME_COUNT_EN
  logic [15:0] frame_count, frame_count_s;
`endif

  int errors = 0;
  int checks = 0;

  always #5 vclock = ~vclock;

  xvga_timing dut (
    .vclock      (vclock),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank       (blank),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef XVGA_FRAME_COUNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  // Small raster: H 8+2+3+3=16, V 6+1+2+2=11, 176 cycles per frame
  xvga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .vclock      (vclock),
    .reset       (reset_s),
    .hcount      (hcount_s),
    .vcount      (vcount_s),
    .hsync       (hsync_s),
    .vsync       (vsync_s),
    .blank       (blank_s),
    .line_start  (line_start_s),
    .frame_start (frame_start_s)
`ifdef XVGA_FRAME_COUNT_EN
    ,
    .frame_count (frame_count_s)
`endif
  );

  task automatic step(input int n);
    repeat (n) @(posedge vclock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    reset_s = 1'b1;
    step(2);
    checks++;
    if ({hcount, vcount, hsync, vsync, blank, line_start, frame_start} !==
        {11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_state: got h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b expected h=0 v=0 hs=1 vs=1 bl=0 ls=1 fs=1",
               hcount, vcount, hsync, vsync, blank, line_start, frame_start);
    end
    checks++;
    if ({hcount_s, vcount_s, hsync_s, vsync_s, blank_s, line_start_s, frame_start_s} !==
        {11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_state_small: got h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b expected h=0 v=0 hs=1 vs=1 bl=0 ls=1 fs=1",
               hcount_s, vcount_s, hsync_s, vsync_s, blank_s, line_start_s, frame_start_s);
    end
    reset = 1'b0;
    reset_s = 1'b0;
    step(1);
    checks++;
    if ({hcount, line_start, frame_start} !== {11'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL after_release: got h=%0d ls=%b fs=%b expected h=1 ls=0 fs=0",
               hcount, line_start, frame_start);
    end
  endtask

  task automatic test_hline;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1023);
    checks++;
    if ({hcount, blank, hsync} !== {11'd1023, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL h1023: got h=%0d bl=%b hs=%b expected h=1023 bl=0 hs=1", hcount, blank, hsync);
    end
    step(1);
    checks++;
    if ({hcount, blank, hsync} !== {11'd1024, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL h1024_blank: got h=%0d bl=%b hs=%b expected h=1024 bl=1 hs=1", hcount, blank, hsync);
    end
    step(23);
    checks++;
    if ({hcount, hsync} !== {11'd1047, 1'b1}) begin
      errors++;
      $display("[TB] FAIL h1047: got h=%0d hs=%b expected h=1047 hs=1", hcount, hsync);
    end
    step(1);
    checks++;
    if ({hcount, hsync} !== {11'd1048, 1'b0}) begin
      errors++;
      $display("[TB] FAIL hsync_fall: got h=%0d hs=%b expected h=1048 hs=0", hcount, hsync);
    end
    step(135);
    checks++;
    if ({hcount, hsync} !== {11'd1183, 1'b0}) begin
      errors++;
      $display("[TB] FAIL h1183: got h=%0d hs=%b expected h=1183 hs=0", hcount, hsync);
    end
    step(1);
    checks++;
    if ({hcount, hsync} !== {11'd1184, 1'b1}) begin
      errors++;
      $display("[TB] FAIL hsync_rise: got h=%0d hs=%b expected h=1184 hs=1", hcount, hsync);
    end
    step(159);
    checks++;
    if ({hcount, vcount, blank, line_start} !== {11'd1343, 10'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL h1343: got h=%0d v=%0d bl=%b ls=%b expected h=1343 v=0 bl=1 ls=0",
               hcount, vcount, blank, line_start);
    end
    step(1);
    checks++;
    if ({hcount, vcount, blank, line_start, frame_start} !== {11'd0, 10'd1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL line_wrap: got h=%0d v=%0d bl=%b ls=%b fs=%b expected h=0 v=1 bl=0 ls=1 fs=0",
               hcount, vcount, blank, line_start, frame_start);
    end
  endtask

  task automatic test_mid_reset;
    step(500);
    checks++;
    if ({hcount, vcount} !== {11'd500, 10'd1}) begin
      errors++;
      $display("[TB] FAIL pre_reset_pos: got h=%0d v=%0d expected h=500 v=1", hcount, vcount);
    end
    reset = 1'b1;
    step(1);
    checks++;
    if ({hcount, vcount, hsync, vsync, blank, line_start, frame_start} !==
        {11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL mid_reset: got h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b expected h=0 v=0 hs=1 vs=1 bl=0 ls=1 fs=1",
               hcount, vcount, hsync, vsync, blank, line_start, frame_start);
    end
    reset = 1'b0;
    step(5);
    checks++;
    if ({hcount, vcount, frame_start} !== {11'd5, 10'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mid_reset_resume: got h=%0d v=%0d fs=%b expected h=5 v=0 fs=0",
               hcount, vcount, frame_start);
    end
  endtask

  // Two full small frames, every cycle against the raster formulas
  task automatic test_frame;
    int vsync_low = 0;
    reset_s = 1'b1;
    step(1);
    reset_s = 1'b0;
    for (int i = 0; i <= 352; i++) begin
      int k, h, v;
      logic [6:0] exp_flags, got_flags;
      k = i % 176;
      h = k % 16;
      v = k / 16;
      exp_flags = {(h >= 10 && h <= 12) ? 1'b0 : 1'b1,
                   (v >= 7 && v <= 8) ? 1'b0 : 1'b1,
                   (h >= 8 || v >= 6) ? 1'b1 : 1'b0,
                   (h == 0) ? 1'b1 : 1'b0,
                   (k == 0) ? 1'b1 : 1'b0,
                   2'b00};
      got_flags = {hsync_s, vsync_s, blank_s, line_start_s, frame_start_s, 2'b00};
      checks++;
      if ({hcount_s, vcount_s, got_flags} !== {11'(h), 10'(v), exp_flags}) begin
        errors++;
        $display("[TB] FAIL frame_cycle %0d: got h=%0d v=%0d hs/vs/bl/ls/fs=%b expected h=%0d v=%0d hs/vs/bl/ls/fs=%b",
                 i, hcount_s, vcount_s, got_flags[6:2], h, v, exp_flags[6:2]);
      end
      if (i < 352) begin
        if (vsync_s == 1'b0) vsync_low++;
        step(1);
      end
    end
    checks++;
    if (vsync_low !== 64) begin
      errors++;
      $display("[TB] FAIL vsync_low_cycles: got %0d expected 64", vsync_low);
    end
  endtask

  task automatic test_mid_reset_small;
    step(69);
    checks++;
    if ({hcount_s, vcount_s} !== {11'd5, 10'd4}) begin
      errors++;
      $display("[TB] FAIL small_pre_reset: got h=%0d v=%0d expected h=5 v=4", hcount_s, vcount_s);
    end
    reset_s = 1'b1;
    step(1);
    checks++;
    if ({hcount_s, vcount_s, hsync_s, vsync_s, blank_s, line_start_s, frame_start_s} !==
        {11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL small_mid_reset: got h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b expected h=0 v=0 hs=1 vs=1 bl=0 ls=1 fs=1",
               hcount_s, vcount_s, hsync_s, vsync_s, blank_s, line_start_s, frame_start_s);
    end
    reset_s = 1'b0;
    step(17);
    checks++;
    if ({hcount_s, vcount_s, line_start_s, frame_start_s} !== {11'd1, 10'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL small_resume: got h=%0d v=%0d ls=%b fs=%b expected h=1 v=1 ls=0 fs=0",
               hcount_s, vcount_s, line_start_s, frame_start_s);
    end
  endtask

`ifdef XVGA_FRAME_COUNT_EN
  task automatic test_frame_count;
    reset_s = 1'b1;
    step(1);
    reset_s = 1'b0;
    checks++;
    if (frame_count_s !== 16'd0) begin
      errors++;
      $display("[TB] FAIL frame_count_reset: got %0d expected 0", frame_count_s);
    end
    for (int n = 1; n <= 3; n++) begin
      step(176);
      checks++;
      if ({frame_start_s, frame_count_s} !== {1'b1, 16'(n)}) begin
        errors++;
        $display("[TB] FAIL frame_count_%0d: got fs=%b count=%0d expected fs=1 count=%0d",
                 n, frame_start_s, frame_count_s, n);
      end
    end
    step(175);
    force dut_s.frame_count = 16'hFFFF;
    #1;
    release dut_s.frame_count;
    step(1);
    checks++;
    if ({frame_start_s, frame_count_s} !== {1'b1, 16'd0}) begin
      errors++;
      $display("[TB] FAIL frame_count_wrap: got fs=%b count=%0d expected fs=1 count=0",
               frame_start_s, frame_count_s);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hline();
    test_mid_reset();
    test_frame();
    test_mid_reset_small();
`ifdef XVGA_FRAME_COUNT_EN
    test_frame_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
